// File: rtl/shift_buffer_loader_pkg.sv
// Shared types and constants for the shift buffer loader.
// Buffer depth and nibble width are common to loader and buffer.
package shift_buffer_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } state_t;

  localparam int NIBBLE_W  = 4;
  localparam int BUF_DEPTH = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_buffer_loader_strobe_timer.sv
// Loadable down-counter timing the HOLD and PULSE phases.
// expired is high while the count sits at zero.
module strobe_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/shift_buffer_loader.sv
// Write-side driver: takes one packed word and serializes it
// as nibble/strobe pairs into the shift buffer, nibble 0 first.
module shift_buffer_loader
  import shift_buffer_loader_pkg::*;
#(
  parameter int NIBBLES = BUF_DEPTH,
  parameter int WIDTH   = NIBBLE_W,
  parameter int HOLD    = 1,
  parameter int PULSE   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NIBBLES*WIDTH-1:0] word_in,
  input  logic                     word_valid,
  output logic                     word_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     write_out,
  output logic                     busy,
  output logic                     done
);

  localparam int TMAX = max2(HOLD, PULSE);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t state_q;
  state_t state_d;

  logic [NIBBLES*WIDTH-1:0] word_q;
  logic [IW-1:0]            idx_q;

  logic          t_load;
  logic [TW-1:0] t_value;
  logic          t_expired;
  logic          accept;
  logic          advance;
  logic          finish;

  strobe_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (t_load),
    .value   (t_value),
    .expired (t_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, timer reloads and burst events.
  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_value = '0;
    accept  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (word_valid && word_ready) begin
          state_d = SETUP;
          t_load  = 1'b1;
          t_value = HOLD_LD;
          accept  = 1'b1;
        end
      end
      SETUP: begin
        if (t_expired) begin
          state_d = STROBE;
          t_load  = 1'b1;
          t_value = PULSE_LD;
        end
      end
      STROBE: begin
        if (t_expired) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d = SETUP;
            t_load  = 1'b1;
            t_value = HOLD_LD;
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word shifter and nibble index; the next nibble
  // sits in the low bits of word_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      word_q <= word_in >> WIDTH;
      idx_q  <= '0;
    end else if (advance) begin
      word_q <= word_q >> WIDTH;
      idx_q  <= idx_q + 1'b1;
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      write_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_ready <= 1'b0;
    end else begin
      write_out  <= (state_d == STROBE);
      busy       <= (state_d != IDLE);
      word_ready <= (state_d == IDLE);
      done       <= finish;
      if (accept) begin
        data_out <= word_in[WIDTH-1:0];
      end else if (advance) begin
        data_out <= word_q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_shift_buffer_loader.sv
// Bench for shift_buffer_loader: two instances (default and
// HOLD=3/PULSE=2) each feeding a behavioural 8x4 shift buffer.
module tb_shift_buffer_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] a_word = '0;
  logic        a_valid = 1'b0;
  logic        a_ready, a_write, a_busy, a_done;
  logic [3:0]  a_data;

  logic [31:0] b_word = '0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_write, b_busy, b_done;
  logic [3:0]  b_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_buffer_loader u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_in    (a_word),
    .word_valid (a_valid),
    .word_ready (a_ready),
    .data_out   (a_data),
    .write_out  (a_write),
    .busy       (a_busy),
    .done       (a_done)
  );

  shift_buffer_loader #(
    .HOLD  (3),
    .PULSE (2)
  ) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_in    (b_word),
    .word_valid (b_valid),
    .word_ready (b_ready),
    .data_out   (b_data),
    .write_out  (b_write),
    .busy       (b_busy),
    .done       (b_done)
  );

  // Behavioural buffers: shift in on strobe rise, slot 7 oldest.
  logic [3:0] abuf [8];
  logic [3:0] bbuf [8];
  int a_rises = 0;
  int b_rises = 0;

  always @(posedge a_write) begin
    for (int i = 7; i > 0; i--) abuf[i] = abuf[i-1];
    abuf[0] = a_data;
    a_rises++;
  end

  always @(posedge b_write) begin
    for (int i = 7; i > 0; i--) bbuf[i] = bbuf[i-1];
    bbuf[0] = b_data;
    b_rises++;
  end

  typedef struct {
    bit          sel;
    logic [31:0] word;
    bit          scramble;
    int          done_at;
    int          o1;
    int          o2;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    logic       ws [64];
    logic [3:0] ds [64];
    logic [31:0] w;
    int n, done_at, rises, k, j;
    int seq_ok, stab_ok, pw_ok, rdy_ok, rdy_done;
    int hold, pulse;
    hold  = v.sel ? 3 : 1;
    pulse = v.sel ? 2 : 1;
    w = v.word;
    k = 0;
    while (!(v.sel ? b_ready : a_ready) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before", int'(v.sel ? b_ready : a_ready), 1);
    if (v.sel) begin
      b_word = v.word;
      b_valid = 1'b1;
    end else begin
      a_word = v.word;
      a_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rdy_ok = 1;
    rdy_done = 0;
    done_at = -1;
    ws[0] = v.sel ? b_write : a_write;
    ds[0] = v.sel ? b_data : a_data;
    if (v.sel ? b_ready : a_ready) rdy_ok = 0;
    n = 1;
    while (n < 60 && done_at < 0) begin
      if (v.scramble) begin
        a_word = $urandom;
        b_word = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      ws[n] = v.sel ? b_write : a_write;
      ds[n] = v.sel ? b_data : a_data;
      if (v.sel ? b_done : a_done) begin
        done_at = n;
        rdy_done = int'(v.sel ? b_ready : a_ready);
      end else if (v.sel ? b_ready : a_ready) begin
        rdy_ok = 0;
      end
      n++;
    end
    rises = 0;
    seq_ok = 1;
    stab_ok = 1;
    pw_ok = 1;
    for (int i = 1; i < n; i++) begin
      if (ws[i] && !ws[i-1]) begin
        if (rises < 8 && ds[i] != w[rises*4 +: 4]) seq_ok = 0;
        for (int h = 1; h <= hold; h++) begin
          if (i - h < 0) stab_ok = 0;
          else if (ws[i-h] || ds[i-h] != ds[i]) stab_ok = 0;
        end
        j = i;
        while (j < n && ws[j]) j++;
        if (j - i != pulse) pw_ok = 0;
        rises++;
      end
    end
    chk("rise_count", rises, 8);
    chk("nibble_order", seq_ok, 1);
    chk("setup_stable", stab_ok, 1);
    chk("pulse_width", pw_ok, 1);
    chk("done_latency", done_at, v.done_at);
    chk("ready_low_busy", rdy_ok, 1);
    chk("ready_at_done", rdy_done, 1);
    chk("buf_out1", int'(v.sel ? bbuf[7] : abuf[7]), v.o1);
    chk("buf_out2", int'(v.sel ? bbuf[6] : abuf[6]), v.o2);
  endtask

  initial begin
    int k, base;
    bit got;
    for (int i = 0; i < 8; i++) begin
      abuf[i] = '0;
      bbuf[i] = '0;
    end
    vecs[0] = '{1'b0, 32'h76543210, 1'b0, 16, 0, 1};
    vecs[1] = '{1'b1, 32'hFEDCBA98, 1'b0, 40, 8, 9};
    vecs[2] = '{1'b0, 32'h13579BDF, 1'b1, 16, 15, 13};
    vecs[3] = '{1'b1, 32'h0F0F0F0F, 1'b1, 40, 15, 0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_data", int'(a_data), 0);
    chk("rst_write", int'(a_write), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_ready", int'(a_ready), 0);
    chk("rst_ready_b", int'(b_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(a_ready), 1);
    @(negedge clk);

    foreach (vecs[i]) run_burst(vecs[i]);

    // Back-to-back with word_valid held high.
    base = a_rises;
    a_word = 32'h11111111;
    a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_word = 32'hAAAAAAAA;
    got = 0;
    k = 0;
    while (!got && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      if (a_done) got = 1;
      k++;
    end
    chk("b2b_first_done", int'(got), 1);
    chk("b2b_ready_in_done", int'(a_ready), 1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    chk("b2b_second_busy", int'(a_busy), 1);
    chk("b2b_second_data", int'(a_data), 10);
    got = 0;
    k = 0;
    while (!got && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      if (a_done) got = 1;
      k++;
    end
    chk("b2b_second_done", int'(got), 1);
    chk("b2b_strobes", a_rises - base, 16);
    chk("b2b_out1", int'(abuf[7]), 10);
    chk("b2b_out2", int'(abuf[6]), 10);

    // Reset during the fourth nibble's strobe.
    @(negedge clk);
    base = a_rises;
    a_word = 32'h76543210;
    a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    got = 0;
    k = 0;
    while (!got && k < 40) begin
      if (a_rises - base == 4 && a_write) got = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    chk("mid_reached", int'(got), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_write", int'(a_write), 0);
    chk("mid_busy", int'(a_busy), 0);
    chk("mid_data", int'(a_data), 0);
    chk("mid_done", int'(a_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ready", int'(a_ready), 1);
    chk("mid_no_done", int'(a_done), 0);
    chk("mid_strobes", a_rises - base, 4);
    chk("mid_slot3", int'(abuf[3]), 0);
    chk("mid_slot0", int'(abuf[0]), 3);
    repeat (4) @(negedge clk);
    chk("mid_not_resumed", a_rises - base, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
